// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - single-car SCAN elevator scheduler
//
// Latches floor calls into a pending bitmap, keeps travelling in the current
// direction while requests remain ahead, and advances the car on tick pulses.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   tick           one-cycle timing enable for the move/door timers
//   call_req       level call buttons, bit i = floor i
//   destination    registered pending-request bitmap
//   sim_state      00 IDLE, 01 MOVE_UP, 10 MOVE_DOWN, 11 DOOR_OPEN
//   current_floor  car position, 0 = ground
module elevator_scheduler #(
    parameter int NUM_FLOORS = 8,
    parameter int MOVE_TICKS = 4,
    parameter int DOOR_TICKS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] destination,
    output logic [1:0]            sim_state,
    output logic [FLOOR_W-1:0]    current_floor
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_t;

    // The timer only ever reaches max(MOVE_TICKS, DOOR_TICKS) - 1.
    localparam int TMAX    = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_TICKS - 1);

    state_t                  state;
    logic                    dir_up;
    logic [TIMER_W-1:0]      timer;
    logic                    above;
    logic                    below;
    logic                    here_req;
    logic [NUM_FLOORS-1:0]   clr;
    logic [FLOOR_W-1:0]      up_floor;
    logic [FLOOR_W-1:0]      down_floor;

    assign sim_state  = state;
    assign here_req   = destination[current_floor];
    assign up_floor   = current_floor + FLOOR_W'(1);
    assign down_floor = current_floor - FLOOR_W'(1);

    // While the door is open the request at this floor is being served, so it
    // is cleared every cycle; a call arriving at the open floor is absorbed.
    assign clr = (state == DOOR_OPEN) ? (NUM_FLOORS'(1) << current_floor) : '0;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (destination[i] && (i > int'(current_floor))) above = 1'b1;
            if (destination[i] && (i < int'(current_floor))) below = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            current_floor <= '0;
            destination   <= '0;
            timer         <= '0;
            dir_up        <= 1'b1;
        end else begin
            destination <= (destination | call_req) & ~clr;
            case (state)
                IDLE: begin
                    // IDLE decisions do not wait for tick.
                    timer <= '0;
                    if (here_req) begin
                        state <= DOOR_OPEN;
                    end else if (above) begin
                        state  <= MOVE_UP;
                        dir_up <= 1'b1;
                    end else if (below) begin
                        state  <= MOVE_DOWN;
                        dir_up <= 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (tick) begin
                        if (timer == MOVE_LAST) begin
                            current_floor <= up_floor;
                            timer         <= '0;
                            if (destination[up_floor]) state <= DOOR_OPEN;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                MOVE_DOWN: begin
                    if (tick) begin
                        if (timer == MOVE_LAST) begin
                            current_floor <= down_floor;
                            timer         <= '0;
                            if (destination[down_floor]) state <= DOOR_OPEN;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (tick) begin
                        if (timer == DOOR_LAST) begin
                            timer <= '0;
                            // Keep the previous direction if work remains there,
                            // otherwise reverse, otherwise rest.
                            if (dir_up && above) begin
                                state <= MOVE_UP;
                            end else if (!dir_up && below) begin
                                state <= MOVE_DOWN;
                            end else if (dir_up && below) begin
                                state  <= MOVE_DOWN;
                                dir_up <= 1'b0;
                            end else if (!dir_up && above) begin
                                state  <= MOVE_UP;
                                dir_up <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - scoreboard bench for elevator_scheduler
module tb_elevator_scheduler;

    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_U = 2'b01;
    localparam logic [1:0] S_D = 2'b10;
    localparam logic [1:0] S_O = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] call_req = 8'h00;
    logic [7:0] destination;
    logic [1:0] sim_state;
    logic [2:0] current_floor;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] st;
        logic [2:0] fl;
        logic [7:0] dst;
    } exp_t;

    exp_t  sb[$];
    int    cycle = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string cur_test = "init";

    elevator_scheduler #(
        .NUM_FLOORS(8),
        .MOVE_TICKS(2),
        .DOOR_TICKS(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .call_req     (call_req),
        .destination  (destination),
        .sim_state    (sim_state),
        .current_floor(current_floor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic t, input logic [7:0] c,
                        input logic [1:0] es, input logic [2:0] ef, input logic [7:0] ed);
        exp_t e;
        rst      = r;
        tick     = t;
        call_req = c;
        e.cyc  = cycle + 1;
        e.name = cur_test;
        e.st   = es;
        e.fl   = ef;
        e.dst  = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rep(input int n, input logic t, input logic [1:0] es,
                       input logic [2:0] ef, input logic [7:0] ed);
        for (int k = 0; k < n; k++) step(1'b0, t, 8'h00, es, ef, ed);
    endtask

    // Monitor: compare every queued expectation whose cycle has been reached.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                e = sb.pop_front();
                vectors++;
                if (e.cyc != cycle || sim_state !== e.st || current_floor !== e.fl ||
                    destination !== e.dst) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d: got state=%b floor=%0d dest=%h, want state=%b floor=%0d dest=%h (due cyc %0d)",
                             e.name, cycle, sim_state, current_floor, destination,
                             e.st, e.fl, e.dst, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // 1: reset wins over random calls
        cur_test = "reset";
        step(1'b1, 1'b1, 8'($urandom), S_I, 3'd0, 8'h00);
        step(1'b1, 1'b1, 8'($urandom), S_I, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h00,        S_I, 3'd0, 8'h00);

        // 2: single call to floor 3
        cur_test = "single_call";
        step(1'b0, 1'b1, 8'h08, S_I, 3'd0, 8'h08);
        rep(2, 1'b1, S_U, 3'd0, 8'h08);
        rep(2, 1'b1, S_U, 3'd1, 8'h08);
        rep(2, 1'b1, S_U, 3'd2, 8'h08);
        rep(1, 1'b1, S_O, 3'd3, 8'h08);
        rep(2, 1'b1, S_O, 3'd3, 8'h00);
        rep(2, 1'b1, S_I, 3'd3, 8'h00);

        // 3: SCAN order from floor 3, calls at 5 and 1, up first
        cur_test = "scan";
        step(1'b0, 1'b1, 8'h22, S_I, 3'd3, 8'h22);
        rep(2, 1'b1, S_U, 3'd3, 8'h22);
        rep(2, 1'b1, S_U, 3'd4, 8'h22);
        rep(1, 1'b1, S_O, 3'd5, 8'h22);
        rep(2, 1'b1, S_O, 3'd5, 8'h02);
        rep(2, 1'b1, S_D, 3'd5, 8'h02);
        rep(2, 1'b1, S_D, 3'd4, 8'h02);
        rep(2, 1'b1, S_D, 3'd3, 8'h02);
        rep(2, 1'b1, S_D, 3'd2, 8'h02);
        rep(1, 1'b1, S_O, 3'd1, 8'h02);
        rep(2, 1'b1, S_O, 3'd1, 8'h00);
        rep(2, 1'b1, S_I, 3'd1, 8'h00);

        // 4: same-floor call, held calls do not extend the door
        cur_test = "same_floor";
        step(1'b1, 1'b1, 8'h00, S_I, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h00, S_I, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h01, S_I, 3'd0, 8'h01);
        step(1'b0, 1'b1, 8'h01, S_O, 3'd0, 8'h01);
        step(1'b0, 1'b1, 8'h01, S_O, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h01, S_O, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h01, S_I, 3'd0, 8'h00);
        step(1'b0, 1'b1, 8'h00, S_I, 3'd0, 8'h00);

        // 5: tick gating mid-move, calls still latch
        cur_test = "tick_gate";
        step(1'b0, 1'b1, 8'h10, S_I, 3'd0, 8'h10);
        rep(2, 1'b1, S_U, 3'd0, 8'h10);
        rep(1, 1'b1, S_U, 3'd1, 8'h10);
        step(1'b0, 1'b0, 8'h04, S_U, 3'd1, 8'h14);
        rep(9, 1'b0, S_U, 3'd1, 8'h14);
        rep(1, 1'b1, S_U, 3'd1, 8'h14);
        rep(1, 1'b1, S_O, 3'd2, 8'h14);
        step(1'b0, 1'b1, 8'h80, S_O, 3'd2, 8'h90);
        rep(1, 1'b1, S_O, 3'd2, 8'h90);
        rep(2, 1'b1, S_U, 3'd2, 8'h90);

        // 6: reset while moving up from floor 2 aborts the move
        cur_test = "mid_reset";
        step(1'b1, 1'b1, 8'h00, S_I, 3'd0, 8'h00);
        rep(5, 1'b1, S_I, 3'd0, 8'h00);

        // IDLE decisions and pending capture proceed with tick low
        cur_test = "idle_no_tick";
        step(1'b0, 1'b0, 8'h02, S_I, 3'd0, 8'h02);
        rep(2, 1'b0, S_U, 3'd0, 8'h02);
        rep(1, 1'b1, S_U, 3'd0, 8'h02);
        rep(1, 1'b1, S_O, 3'd1, 8'h02);
        rep(2, 1'b1, S_O, 3'd1, 8'h00);
        rep(1, 1'b1, S_I, 3'd1, 8'h00);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
